// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus bundle: instruction memory request/response and
// the buffer head handed to decode.
interface ifetch_queue_if;
  logic        o_imem_req;
  logic [31:0] o_imem_raddr;
  logic        i_imem_ready;
  logic        i_imem_valid;
  logic [31:0] i_imem_rdata;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready;

  modport master (
    output o_imem_req,
    output o_imem_raddr,
    input  i_imem_ready,
    input  i_imem_valid,
    input  i_imem_rdata,
    output o_inst_valid,
    output o_inst,
    output o_inst_pc,
    input  i_inst_ready
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_raddr,
    output i_imem_ready,
    output i_imem_valid,
    output i_imem_rdata,
    input  o_inst_valid,
    input  o_inst,
    input  o_inst_pc,
    output i_inst_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// Prefetch queue with redirect/stale-drop handling.
// Optional misaligned-redirect trap: IFETCH_MISALIGN_TRAP_EN.
module ifetch_queue #(
  parameter logic [31:0] RESET_ADDR = 32'h00000000,
  parameter int          DEPTH      = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  ifetch_queue_if.master bus,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_fetch_trap
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   pc_q  [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop;
  logic          trap_q;
  logic [31:0]   redir_pc;
  logic [CW:0]   used;
  logic          accept;
  logic          rsp;
  logic          wr;
  logic          pop;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign redir_pc = i_redirect_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      trap_q <= 1'b0;
    end else if (i_redirect) begin
      trap_q <= |i_redirect_pc[1:0];
    end
  end
`else
  logic unused_rpc;
  assign unused_rpc = ^i_redirect_pc[1:0];
  assign redir_pc   = {i_redirect_pc[31:2], 2'b00};
  assign trap_q     = 1'b0;
`endif

  // Space check counts stale in-flight responses too.
  assign used = {1'b0, count} + {1'b0, outst};

  assign bus.o_imem_req   = !i_rst && !i_redirect &&
                            !trap_q && (used < DEPTH_W);
  assign bus.o_imem_raddr = {fetch_pc[31:2], 2'b00};
  assign bus.o_inst_valid = !i_rst && (count != '0);
  assign bus.o_inst       = mem_q[rptr];
  assign bus.o_inst_pc    = pc_q[rptr];
  assign o_fetch_trap     = trap_q && !i_rst;

  assign accept = bus.o_imem_req && bus.i_imem_ready;
  assign rsp    = bus.i_imem_valid;
  assign wr     = rsp && !i_redirect && (drop == '0);
  assign pop    = bus.o_inst_valid && bus.i_inst_ready &&
                  !i_redirect;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc <= RESET_ADDR;
      rsp_pc   <= RESET_ADDR;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      outst    <= '0;
      drop     <= '0;
    end else begin
      outst <= outst + CW'(accept) - CW'(rsp);
      if (i_redirect) begin
        fetch_pc <= redir_pc;
        rsp_pc   <= redir_pc;
        wptr     <= '0;
        rptr     <= '0;
        count    <= '0;
        // Everything still in flight after this edge is stale.
        drop     <= outst - CW'(rsp);
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (rsp && (drop != '0)) begin
          drop <= drop - CW'(1);
        end
        if (wr) begin
          wptr   <= wptr + AW'(1);
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop) begin
          rptr <= rptr + AW'(1);
        end
        count <= count + CW'(wr) - CW'(pop);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && wr) begin
      mem_q[wptr] <= bus.i_imem_rdata;
      pc_q[wptr]  <= rsp_pc;
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed table plus multi-cycle sequences for ifetch_queue.
// Memory model responds in order with per-request latency.
module tb_ifetch_queue;
  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_trap;

  ifetch_queue_if bus();

  ifetch_queue #(
    .RESET_ADDR (32'h00000000),
    .DEPTH      (4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .bus           (bus),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_fetch_trap  (fetch_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ir;
    logic        rd;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic        trap;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;

  vec_t  tv[$];
  mreq_t mq[$];
  int    cycn;
  int    checks;
  int    failures;
  int    ncons;
  logic [31:0] exp_pc;

  logic        s_req;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_inst;
  logic        s_trap;
  logic        s_cons;

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s idx=%0d got=%h exp=%h",
               nm, idx, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic ir,
                     input logic rd, input logic [31:0] rpc,
                     input logic req, input logic [31:0] addr,
                     input logic v, input logic [31:0] pc,
                     input logic trap);
    vec_t e;
    e.rst = r; e.ir = ir; e.rd = rd; e.rpc = rpc;
    e.req = req; e.addr = addr; e.v = v; e.pc = pc;
    e.trap = trap;
    tv.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic ir,
                     input logic rd, input logic [31:0] rpc,
                     input int lat, input logic mrdy);
    logic rv;
    rst = r;
    bus.i_inst_ready = ir;
    redirect = rd;
    redirect_pc = rpc;
    bus.i_imem_ready = mrdy;
    rv = !r && (mq.size() > 0) && (mq[0].due <= cycn);
    bus.i_imem_valid = rv;
    bus.i_imem_rdata = rv ? f(mq[0].a) : 32'h0;
    #1;
    s_req   = bus.o_imem_req;
    s_addr  = bus.o_imem_raddr;
    s_valid = bus.o_inst_valid;
    s_pc    = bus.o_inst_pc;
    s_inst  = bus.o_inst;
    s_trap  = fetch_trap;
    s_cons  = s_valid && ir && !rd && !r;
    if (r) begin
      mq.delete();
    end else begin
      if (rv) void'(mq.pop_front());
      if (s_req && mrdy) begin
        mreq_t m;
        m.a = s_addr;
        m.due = cycn + lat;
        mq.push_back(m);
      end
    end
    @(posedge clk);
    cycn++;
    @(negedge clk);
  endtask

  task automatic score();
    if (s_cons) begin
      chk("stream_pc", ncons, s_pc, exp_pc);
      chk("stream_inst", ncons, s_inst, f(exp_pc));
      exp_pc = exp_pc + 32'd4;
      ncons++;
    end
  endtask

  initial begin
    logic [31:0] t;
    logic ir;
    logic rd;
    logic [31:0] rpc;
    checks = 0; failures = 0; cycn = 0; ncons = 0;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    bus.i_imem_ready = 1'b0; bus.i_imem_valid = 1'b0;
    bus.i_imem_rdata = 32'h0; bus.i_inst_ready = 1'b0;

    //  rst ir rd rpc          req addr         v  pc           trap
    add(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
    add(0, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        0);
    add(0, 1, 0, 32'h0,        1, 32'h4,        0, 32'h0,        0);
    add(0, 1, 0, 32'h0,        1, 32'h8,        1, 32'h0,        0);
    add(0, 1, 0, 32'h0,        1, 32'hC,        1, 32'h4,        0);
    add(0, 1, 0, 32'h0,        1, 32'h10,       1, 32'h8,        0);
    add(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
    add(0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        0);
    add(0, 0, 0, 32'h0,        1, 32'h4,        0, 32'h0,        0);
    add(0, 0, 0, 32'h0,        1, 32'h8,        1, 32'h0,        0);
    add(0, 0, 0, 32'h0,        1, 32'hC,        1, 32'h0,        0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0);
    add(0, 0, 0, 32'h0,        1, 32'h10,       1, 32'h4,        0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0);
    add(0, 0, 0, 32'h0,        1, 32'h14,       1, 32'h8,        0);
    add(0, 1, 1, 32'h100,      0, 32'h0,        1, 32'h8,        0);
    add(0, 1, 0, 32'h0,        1, 32'h100,      0, 32'h0,        0);
    add(0, 1, 0, 32'h0,        1, 32'h104,      0, 32'h0,        0);
    add(0, 1, 0, 32'h0,        1, 32'h108,      1, 32'h100,      0);
    add(0, 1, 0, 32'h0,        1, 32'h10C,      1, 32'h104,      0);
    add(0, 1, 1, 32'h102,      0, 32'h0,        1, 32'h108,      0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    add(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1);
    add(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1);
    add(0, 1, 1, 32'h200,      0, 32'h0,        0, 32'h0,        1);
    add(0, 1, 0, 32'h0,        1, 32'h200,      0, 32'h0,        0);
    add(0, 1, 0, 32'h0,        1, 32'h204,      0, 32'h0,        0);
    add(0, 1, 0, 32'h0,        1, 32'h208,      1, 32'h200,      0);
`else
    add(0, 1, 0, 32'h0,        1, 32'h100,      0, 32'h0,        0);
    add(0, 1, 0, 32'h0,        1, 32'h104,      0, 32'h0,        0);
    add(0, 1, 0, 32'h0,        1, 32'h108,      1, 32'h100,      0);
    add(0, 1, 1, 32'hFFFFFFF8, 0, 32'h0,        1, 32'h104,      0);
    add(0, 1, 0, 32'h0,        1, 32'hFFFFFFF8, 0, 32'h0,        0);
    add(0, 1, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h0,        0);
    add(0, 1, 0, 32'h0,        1, 32'h0,        1, 32'hFFFFFFF8, 0);
    add(0, 1, 0, 32'h0,        1, 32'h4,        1, 32'hFFFFFFFC, 0);
    add(0, 1, 0, 32'h0,        1, 32'h8,        1, 32'h0,        0);
`endif

    @(negedge clk);
    foreach (tv[i]) begin
      cyc(tv[i].rst, tv[i].ir, tv[i].rd, tv[i].rpc, 1, 1'b1);
      chk("req", i, {31'h0, s_req}, {31'h0, tv[i].req});
      if (tv[i].req) chk("raddr", i, s_addr, tv[i].addr);
      chk("valid", i, {31'h0, s_valid}, {31'h0, tv[i].v});
      if (tv[i].v) begin
        chk("pc", i, s_pc, tv[i].pc);
        chk("inst", i, s_inst, f(tv[i].pc));
      end
      chk("trap", i, {31'h0, s_trap}, {31'h0, tv[i].trap});
    end

    // Redirect with three requests in flight at latency 3.
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 3, 1'b1);
      chk("l3_req", k, {31'h0, s_req}, 32'h1);
    end
    chk("l3_outst", 0, mq.size(), 32'd3);
    cyc(1'b0, 1'b1, 1'b1, 32'h100, 3, 1'b1);
    chk("l3_rdvalid", 0, {31'h0, s_valid}, 32'h0);
    exp_pc = 32'h100;
    ncons = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 3, 1'b1);
      score();
    end
    chk("l3_progress", 0, {31'h0, ncons >= 2}, 32'h1);

    // Random readiness, latency and aligned redirects.
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1, 1'b1);
    exp_pc = 32'h0;
    ncons = 0;
    for (int k = 0; k < 3000; k++) begin
      ir = ($urandom % 3) != 0;
      rd = ($urandom % 97) == 0;
      t  = $urandom;
      rpc = t & 32'hFFFFFFFC;
      cyc(1'b0, ir, rd, rpc, int'($urandom_range(1, 4)),
          ($urandom % 4) != 0);
      score();
      if (rd) exp_pc = rpc;
      if (s_req) chk("rnd_align", k, {30'h0, s_addr[1:0]}, 32'h0);
    end
    chk("rnd_progress", 0, {31'h0, ncons > 500}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 32'h00000000, the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, the prefetch buffer entries; legal values are powers of two, 2..16.
REQ-003 SHALL have port i_clk, input, 1 bit, the single global clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit, reset; synchronous, active-high.
REQ-005 SHALL have port o_imem_req, output, 1 bit, fetch request valid.
REQ-006 SHALL have port o_imem_raddr, output, 32 bits, fetch address; always 4-byte aligned.
REQ-007 SHALL have port i_imem_ready, input, 1 bit; the memory accepts the request when o_imem_req && i_imem_ready.
REQ-008 SHALL have ports i_imem_valid (input, 1 bit) and i_imem_rdata (input, 32 bits), the response; responses return in request order, at least 1 cycle after acceptance.
REQ-009 SHALL have ports o_inst_valid (output, 1), o_inst (output, 32) and o_inst_pc (output, 32), the buffer head presented to decode.
REQ-010 SHALL have port i_inst_ready, input, 1 bit; the head is consumed when o_inst_valid && i_inst_ready.
REQ-011 SHALL have ports i_redirect (input, 1) and i_redirect_pc (input, 32), a branch/jump/trap redirect.
REQ-012 SHALL have port o_fetch_trap, output, 1 bit, misaligned-redirect flag (see Configuration).

Function
REQ-013 SHALL keep a fetch PC register; it advances by 4 on each accepted request, wrapping 32'hFFFFFFFC -> 0.
REQ-014 SHALL assert o_imem_req only when (buffer occupancy + outstanding requests) < DEPTH, i_redirect is low and o_fetch_trap is low.
REQ-015 SHALL count outstanding requests: +1 on acceptance, -1 on response; the counter is clog2(DEPTH)+1 bits wide.
REQ-016 SHALL write each non-stale response into the buffer tail together with its PC; o_inst_valid rises the cycle after the write (no bypass).
REQ-017 SHALL support a write and a consume in the same cycle while full or empty without loss or duplication.
REQ-018 SHALL hold o_inst and o_inst_pc stable while o_inst_valid is high and i_inst_ready is low.
REQ-019 On i_redirect, SHALL in that cycle empty the buffer, ignore any consume, load the fetch PC with i_redirect_pc, and mark every outstanding request (including those accepted that cycle) stale.
REQ-020 SHALL drop stale responses by decrementing a drop counter instead of writing the buffer; a response arriving in the redirect cycle is dropped.
REQ-021 SHALL accept a new request in the cycle after a redirect even if stale responses are still pending; the buffer-space check includes them.
REQ-022 SHALL treat back-to-back redirects as independent: the last one wins and all earlier in-flight responses are dropped.

Reset
REQ-023 On i_rst, SHALL set fetch PC = RESET_ADDR and empty the buffer, and clear the outstanding counter, the drop counter and o_fetch_trap.
REQ-024 While in reset, SHALL drive o_imem_req=0, o_inst_valid=0 and o_fetch_trap=0; o_inst and o_inst_pc are don't-care.
REQ-025 Reset mid-operation SHALL discard all in-flight responses; the memory model must also reset in the same cycle.
REQ-026 SHALL issue the first request in the first cycle after i_rst deasserts.

Configuration
REQ-027 SHALL honour macro IFETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with i_redirect_pc[1:0] != 0 sets o_fetch_trap the next cycle and blocks further requests; the flag clears only on an aligned redirect or reset.
- Undefined: i_redirect_pc[1:0] is forced to 0 and o_fetch_trap is tied 0.

Verification
REQ-028 Reset, memory always ready, latency 1, i_inst_ready=1 -> o_inst_pc = 0x0, 0x4, 0x8, ... one per cycle from cycle 3 onward, no gaps.
REQ-029 DEPTH=4, i_inst_ready=0 -> exactly 4 requests accepted, then o_imem_req=0; one consume -> exactly one new request.
REQ-030 i_redirect with i_redirect_pc=0x100 while 3 requests are outstanding at latency 3 -> those 3 responses are dropped; the next o_inst_pc is 0x100, then 0x104.
REQ-031 Redirect in the same cycle as a response and a consume -> the buffer is empty the next cycle; the consume and the response have no effect.
REQ-032 With the macro defined, redirect to 0x102 -> o_fetch_trap=1 and no requests; a later redirect to 0x200 -> trap clears and fetch resumes at 0x200. With the macro undefined, redirect to 0x102 -> fetch resumes at 0x100.
REQ-033 Random i_imem_ready, latency 1..4 and random i_inst_ready -> the consumed PC stream is sequential from the last redirect, with no duplicates and no drops.
